// File: rtl/sel_reg_scan.sv
// Registered channel selector with a one-shot auto-scan sequencer.
// Captures either an OR-combined direct select or every channel in order.
module sel_reg_scan #(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic           mode,
    input  logic           start,
    input  logic [K-1:0]   sel_a,
    input  logic [K-1:0]   sel_b,
    input  logic [N*(2**K)-1:0] d,
    output logic [N-1:0]   out,
    output logic [K-1:0]   ch,
    output logic           valid,
    output logic           busy,
    output logic           done
);
    localparam int C = 2 ** K;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t         state, state_n;
    logic [K-1:0]   idx, idx_n;
    logic [N-1:0]   out_n;
    logic [K-1:0]   ch_n;
    logic           valid_n;
    logic           done_n;
    logic [K-1:0]   sel;

    function automatic logic [N-1:0] pick(input logic [N*C-1:0] v, input logic [K-1:0] s);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < C; i++) begin
            if (s == K'(i)) r = v[i*N +: N];
        end
        return r;
    endfunction

    assign sel  = sel_a | sel_b;
    assign busy = (state == SCAN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            out   <= '0;
            ch    <= '0;
            valid <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            out   <= out_n;
            ch    <= ch_n;
            valid <= valid_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        out_n   = out;
        ch_n    = ch;
        valid_n = 1'b0;
        done_n  = 1'b0;
        if (clr) begin
            state_n = IDLE;
            idx_n   = '0;
            out_n   = '0;
            ch_n    = '0;
        end else begin
            case (state)
                IDLE: begin
                    // A scan launch takes precedence over any capture on the same edge.
                    if (mode && start) begin
                        state_n = SCAN;
                        idx_n   = '0;
                    end else if (!mode && en) begin
                        out_n   = pick(d, sel);
                        ch_n    = sel;
                        valid_n = 1'b1;
                    end
                end
                SCAN: begin
                    if (en) begin
                        out_n   = pick(d, idx);
                        ch_n    = idx;
                        valid_n = 1'b1;
                        if (idx == K'(C - 1)) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                            idx_n   = '0;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sel_reg_scan.sv
// Directed and randomized checks of sel_reg_scan against a queue-based reference model.
`timescale 1ns/1ps
module tb_sel_reg_scan;
    localparam int N = 8;
    localparam int K = 2;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst, clr, en, mode, start;
    logic [K-1:0]   sel_a, sel_b;
    logic [N*C-1:0] d;
    logic [N-1:0]   out;
    logic [K-1:0]   ch;
    logic           valid, busy, done;

    int errors = 0;
    int checks = 0;

    // Reference: pending scan channels held in a queue; busy means the queue is non-empty.
    int q[$];
    int m_out, m_ch, m_valid, m_done;

    sel_reg_scan #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .start(start),
        .sel_a(sel_a), .sel_b(sel_b), .d(d),
        .out(out), .ch(ch), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int chan(input logic [N*C-1:0] dv, input int c);
        logic [N*C-1:0] t;
        t = dv >> (N * c);
        return int'(t[N-1:0]);
    endfunction

    task automatic model_reset();
        q.delete();
        m_out = 0; m_ch = 0; m_valid = 0; m_done = 0;
    endtask

    task automatic model_edge();
        int c;
        if (clr) begin
            q.delete();
            m_out = 0; m_ch = 0; m_valid = 0; m_done = 0;
        end else if (q.size() != 0) begin
            if (en) begin
                c = q.pop_front();
                m_out = chan(d, c); m_ch = c; m_valid = 1;
                m_done = (q.size() == 0) ? 1 : 0;
            end else begin
                m_valid = 0; m_done = 0;
            end
        end else begin
            m_done = 0;
            if (mode && start) begin
                for (int i = 0; i < C; i++) q.push_back(i);
                m_valid = 0;
            end else if (!mode && en) begin
                c = int'(sel_a | sel_b);
                m_out = chan(d, c); m_ch = c; m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out"},   32'(out),   32'(m_out));
        chk({tag, ".ch"},    32'(ch),    32'(m_ch));
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".done"},  32'(done),  32'(m_done));
        chk({tag, ".busy"},  32'(busy),  (q.size() != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic c, input logic e, input logic m, input logic s,
                         input logic [K-1:0] a, input logic [K-1:0] b);
        clr = c; en = e; mode = m; start = s; sel_a = a; sel_b = b;
    endtask

    initial begin
        logic [7:0] scan_exp [4];
        scan_exp[0] = 8'h11; scan_exp[1] = 8'h22; scan_exp[2] = 8'h33; scan_exp[3] = 8'h44;

        rst = 1'b1;
        drive(0, 0, 0, 0, 2'b00, 2'b00);
        d = 32'h4433_2211;
        #12;
        model_reset();
        check_all("reset");
        rst = 1'b0;

        // Direct select with OR-combined terms, then hold.
        drive(0, 1, 0, 0, 2'b01, 2'b10);
        tick("direct");
        chk("direct.lit_out", 32'(out), 32'h44);
        chk("direct.lit_ch", 32'(ch), 32'd3);
        drive(0, 0, 0, 0, 2'b01, 2'b10);
        tick("direct_hold");
        chk("hold.lit_out", 32'(out), 32'h44);

        // Start with mode=0 is ignored.
        drive(0, 0, 0, 1, 2'b00, 2'b00);
        tick("start_mode0");

        // Clear outranks a launch; then a plain launch ignores en.
        drive(1, 1, 1, 1, 2'b00, 2'b00);
        tick("prio_clr");
        drive(0, 1, 1, 1, 2'b00, 2'b00);
        tick("prio_start");
        chk("prio.lit_busy", 32'(busy), 32'd1);
        chk("prio.lit_valid", 32'(valid), 32'd0);

        // Full unstalled scan.
        drive(0, 1, 1, 0, 2'b11, 2'b11);
        for (int i = 0; i < C; i++) begin
            tick("scan");
            chk("scan.lit_out", 32'(out), 32'(scan_exp[i]));
            chk("scan.lit_done", 32'(done), (i == C - 1) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 1, 0, 2'b00, 2'b00);
        tick("after_scan");

        // Stalled scan, then a back-to-back launch right after done.
        drive(0, 1, 1, 1, 2'b00, 2'b00);
        tick("launch2");
        start = 1'b0;
        tick("s2_0");
        tick("s2_1");
        en = 1'b0;
        tick("stall0");
        tick("stall1");
        chk("stall.lit_out", 32'(out), 32'h22);
        en = 1'b1;
        tick("resume");
        chk("resume.lit_out", 32'(out), 32'h33);
        tick("s2_3");
        start = 1'b1;
        tick("b2b_launch");
        chk("b2b.lit_busy", 32'(busy), 32'd1);

        // Abort by clear, then restart.
        start = 1'b0;
        tick("a_0");
        tick("a_1");
        clr = 1'b1;
        tick("abort");
        chk("abort.lit_out", 32'(out), 32'h00);
        drive(0, 1, 1, 1, 2'b00, 2'b00);
        tick("restart");
        start = 1'b0;
        tick("r_0");
        chk("restart.lit_out", 32'(out), 32'h11);
        tick("r_1");
        tick("r_2");

        // Asynchronous reset mid-cycle, then held through an edge.
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        drive(0, 1, 1, 1, 2'b01, 2'b01);
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b0;
        drive(0, 1, 0, 0, 2'b10, 2'b00);
        tick("post_rst");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            d     = $urandom;
            clr   = ($urandom_range(0, 19) == 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = $urandom_range(0, 1);
            start = ($urandom_range(0, 2) == 0);
            sel_a = K'($urandom);
            sel_b = K'($urandom);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sel_reg_scan.md
SEL_REG_SCAN -- requirements
Module: sel_reg_scan

Interface
REQ-001 Parameter N, default 8: data width per channel, N >= 1.
REQ-002 Parameter K, default 2: select width, K >= 1; channel count C = 2^K.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous clear, active-high.
REQ-006 en  input  1  capture enable / scan advance; 0 = stall.
REQ-007 mode  input  1  0 = direct select, 1 = auto-scan.
REQ-008 start  input  1  scan launch request, sampled only in IDLE with mode=1.
REQ-009 sel_a  input  K  select term A.
REQ-010 sel_b  input  K  select term B.
REQ-011 d  input  N*C  packed data; channel i occupies bits [i*N +: N].
REQ-012 out  output  N  registered selected data.
REQ-013 ch  output  K  registered index of the channel currently in out.
REQ-014 valid  output  1  registered; high for exactly the cycle after each capture edge.
REQ-015 busy  output  1  high while the FSM is in SCAN, decoded from the state register only.
REQ-016 done  output  1  registered one-cycle pulse marking completion of a scan.

Function
REQ-017 The FSM has exactly two states, IDLE and SCAN, plus a K-bit scan index idx.
REQ-018 Effective direct select sel = sel_a | sel_b (bitwise OR).
REQ-019 IDLE, mode=0, en=1: at the edge, out <= d[sel], ch <= sel, valid <= 1.
REQ-020 IDLE, en=0, with no scan launch: out and ch hold; valid <= 0.
REQ-021 IDLE, mode=1, start=1: at the edge, state <= SCAN, idx <= 0, out and ch hold, valid <= 0; en is ignored on this edge.
REQ-022 In IDLE, start with mode=0 is ignored.
REQ-023 SCAN, en=1: at the edge, out <= d[idx], ch <= idx, valid <= 1, and idx increments.
REQ-024 SCAN, en=1, idx = C-1: the capture also sets done <= 1, state <= IDLE, and idx <= 0; idx never wraps inside SCAN.
REQ-025 SCAN, en=0: stall; idx, out, ch and state hold; valid <= 0; done <= 0.
REQ-026 Unstalled scan latency: start sampled at edge t0; channel i is captured at edge t0+1+i; done and the last valid are high together in the cycle after edge t0+C.
REQ-027 In SCAN, mode, start, sel_a and sel_b are ignored.
REQ-028 done is 0 on every edge other than the final scan capture.
REQ-029 clr=1 at an edge forces out=0, ch=0, valid=0, done=0, idx=0 and state=IDLE.
REQ-030 clr has priority over every other input, including start and en.
REQ-031 clr during SCAN aborts the scan; no done is issued.
REQ-032 Back-to-back scans: the cycle after done, IDLE accepts a new start with no dead cycle.
REQ-033 K=1 (C=2) is legal; the scan then takes 2 capture edges.

Reset
REQ-034 rst=1 immediately forces out=0, ch=0, valid=0, done=0, idx=0 and state=IDLE (busy=0), with no clock edge required.
REQ-035 While rst=1, the block ignores clk and all inputs.
REQ-036 After rst deasserts, the first active edge behaves as from IDLE.

Verification (N=8, K=2, d channels 0..3 = 0x11, 0x22, 0x33, 0x44)
REQ-037 Assert rst mid-cycle after out=0x33 -> out=0x00, valid=0 and busy=0 before the next clk edge.
REQ-038 Direct mode: mode=0, en=1, sel_a=01, sel_b=10 -> after the edge, out=0x44, ch=3, valid=1; then en=0 -> out stays 0x44, valid=0.
REQ-039 Scan: mode=1, one-cycle start, en=1 -> over the next 4 edges, out=0x11, 0x22, 0x33, 0x44 with valid=1 each; done=1 only with 0x44; busy=0 afterwards.
REQ-040 Stall: en=0 for 2 cycles after the 0x22 capture -> out holds 0x22, valid=0, ch=1; on en=1 the scan resumes with 0x33.
REQ-041 Abort: clr=1 in SCAN after the 0x22 capture -> next edge gives out=0x00, busy=0, done never asserted; a new start then restarts from 0x11.
REQ-042 Priority: IDLE with mode=1, start=1, en=1 -> no capture, valid=0, busy=1; the same edge with clr=1 -> state stays IDLE.
